// File: rtl/amba_write_arbiter_pkg.sv
// Shared types and constants for the two-requester AMBA write arbiter.
// Holds the FSM state encoding, the legal register map and a saturating counter helper.
package amba_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ERR   = 2'd3
  } arb_state_t;

  localparam logic [7:0] ADDR_CTRL    = 8'h20;
  localparam logic [7:0] ADDR_TX_SLOT = 8'h21;
  localparam logic [7:0] ADDR_RX_SLOT = 8'h22;
  localparam logic [7:0] ADDR_INT_B0  = 8'h23;
  localparam logic [7:0] ADDR_INT_B1  = 8'h24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/amba_write_arbiter_if.sv
// Bundles both requester ports and the downstream write channel of the arbiter.
// slave = arbiter view, master = requesters plus downstream target.
interface amba_write_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req0_err;
  logic       req1_valid;
  logic [7:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       req1_err;
  logic       m_valid;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  logic       m_ready;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  m_ready,
    output req0_ready, req0_err, req1_ready, req1_err,
    output m_valid, m_addr, m_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output m_ready,
    input  req0_ready, req0_err, req1_ready, req1_err,
    input  m_valid, m_addr, m_data
  );
endinterface

// File: rtl/amba_write_arbiter_rr.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
// Purely combinational; the last-grant pointer lives in the parent FSM.
module amba_rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt_vld_o,
  output logic gnt_idx_o
);

  always_comb begin
    gnt_vld_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) gnt_idx_o = ~last_i;
    else                      gnt_idx_o = valid1_i;
  end

endmodule

// File: rtl/amba_write_arbiter.sv
// Arbitrates two write requesters onto one downstream channel with address
// range checking, an ISSUE timeout and a saturating error counter.
module amba_write_arbiter
  import amba_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  ADDR_MIN       = ADDR_CTRL,
  parameter logic [7:0]  ADDR_MAX       = ADDR_INT_B1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  amba_write_arbiter_if.slave  bus,
  output logic                 grant_id,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t state_q, state_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_addr_q, m_addr_d;
  logic [7:0] m_data_q, m_data_d;
  logic [1:0] rdy_q, rdy_d;
  logic [1:0] err_q, err_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic [7:0] errcnt_q, errcnt_d;
  logic [7:0] tmo_q, tmo_d;

  logic       gnt_vld, gnt_idx;
  logic [7:0] sel_addr, sel_data;
  logic       sel_legal;

  amba_rr_arb2 u_rr (
    .valid0_i  (bus.req0_valid),
    .valid1_i  (bus.req1_valid),
    .last_i    (last_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_addr  = gnt_idx ? bus.req1_addr : bus.req0_addr;
  assign sel_data  = gnt_idx ? bus.req1_data : bus.req0_data;
  assign sel_legal = (sel_addr >= ADDR_MIN) && (sel_addr <= ADDR_MAX);

  // Outputs are registered from the next state, so each output takes the value
  // belonging to the state it enters on the same edge.
  always_comb begin
    state_d  = state_q;
    m_valid_d = m_valid_q;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    rdy_d    = 2'b00;
    err_d    = 2'b00;
    grant_d  = grant_q;
    last_d   = last_q;
    errcnt_d = errcnt_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          grant_d  = gnt_idx;
          m_addr_d = sel_addr;
          m_data_d = sel_data;
          tmo_d    = 8'd0;
          if (sel_legal) begin
            state_d   = ISSUE;
            m_valid_d = 1'b1;
          end else begin
            state_d        = ERR;
            rdy_d[gnt_idx] = 1'b1;
            err_d[gnt_idx] = 1'b1;
            errcnt_d       = sat_inc8(errcnt_q);
          end
        end
      end
      ISSUE: begin
        // A handshake on the last timeout cycle still completes normally.
        if (bus.m_ready) begin
          state_d        = RESP;
          m_valid_d      = 1'b0;
          rdy_d[grant_q] = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d        = ERR;
          m_valid_d      = 1'b0;
          rdy_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          errcnt_d       = sat_inc8(errcnt_q);
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP, ERR: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_addr_q  <= 8'd0;
      m_data_q  <= 8'd0;
      rdy_q     <= 2'b00;
      err_q     <= 2'b00;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      errcnt_q  <= 8'd0;
      tmo_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      errcnt_q  <= errcnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.m_valid    = m_valid_q;
  assign bus.m_addr     = m_addr_q;
  assign bus.m_data     = m_data_q;
  assign bus.req0_ready = rdy_q[0];
  assign bus.req1_ready = rdy_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign err_count      = errcnt_q;

endmodule

// File: tb/tb_amba_write_arbiter.sv
// Scoreboard bench for amba_write_arbiter: expected downstream writes and
// completions are queued when requests are driven and checked as they appear.
module tb_amba_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic       grant_id;
  logic       busy;
  logic [7:0] err_count;

  amba_write_arbiter_if bus();

  amba_write_arbiter #(
    .TIMEOUT_CYCLES (16),
    .ADDR_MIN       (8'h20),
    .ADDR_MAX       (8'h24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int exp_ec = 0;

  logic [15:0] mq[$];
  logic [1:0]  rq[$];
  logic [15:0] me;
  logic [1:0]  re;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue expectations for one request; tmo marks a legal write that will time out.
  task automatic drv(input bit id, input logic [7:0] a, input logic [7:0] d, input bit tmo);
    bit legal;
    legal = (a >= 8'h20) && (a <= 8'h24);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d;
    end
    if (legal && !tmo) begin
      mq.push_back({a, d});
      rq.push_back({id, 1'b0});
    end else begin
      rq.push_back({id, 1'b1});
      exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
    end
  endtask

  task automatic run(input int n_exp, output int n_got, output int mv_cyc);
    n_got  = 0;
    mv_cyc = 0;
    for (int c = 0; c < 400 && n_got < n_exp; c++) begin
      @(negedge clk);
      if (bus.m_valid) mv_cyc++;
      if (bus.req0_ready || bus.req1_ready) n_got++;
    end
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("run_done", n_got, n_exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        if (mq.size() == 0) chk("m_unexpected", mq.size(), 1);
        else begin
          me = mq.pop_front();
          chk("m_addr", 32'(bus.m_addr), 32'(me[15:8]));
          chk("m_data", 32'(bus.m_data), 32'(me[7:0]));
        end
      end
      if (bus.req0_ready || bus.req1_ready) begin
        if (rq.size() == 0) chk("rsp_unexpected", rq.size(), 1);
        else begin
          re = rq.pop_front();
          chk("rsp_id",      32'(bus.req1_ready), 32'(re[1]));
          chk("rsp_excl",    32'(bus.req0_ready & bus.req1_ready), 0);
          chk("rsp_err",     32'(re[1] ? bus.req1_err : bus.req0_err), 32'(re[0]));
          chk("rsp_oth_err", 32'(re[1] ? bus.req0_err : bus.req1_err), 0);
          chk("rsp_gid",     32'(grant_id), 32'(re[1]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, mv, mv2, seen;
    logic [7:0] tbl_a [4];
    tbl_a[0] = 8'h1F; tbl_a[1] = 8'h20; tbl_a[2] = 8'h24; tbl_a[3] = 8'h25;

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_addr",  32'(bus.m_addr), 0);
    chk("rst_m_data",  32'(bus.m_data), 0);
    chk("rst_ready",   32'({bus.req0_ready, bus.req1_ready, bus.req0_err, bus.req1_err}), 0);
    chk("rst_grant",   32'(grant_id), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_errcnt",  32'(err_count), 0);

    // Simultaneous requests held high: grants alternate starting with req0.
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_addr = 8'h20; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 8'h22; bus.req1_data = 8'h99;
    for (int i = 0; i < 2; i++) begin
      mq.push_back({8'h20, 8'h11}); rq.push_back(2'b00);
      mq.push_back({8'h22, 8'h99}); rq.push_back(2'b10);
    end
    run(4, n, mv);

    // Single legal write with exact latency.
    @(posedge clk); #1;
    drv(1'b0, 8'h21, 8'hA5, 1'b0);
    @(negedge clk);
    chk("lat_t0_mvalid", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("lat_t1_mvalid", 32'(bus.m_valid), 1);
    chk("lat_t1_addr",   32'(bus.m_addr), 'h21);
    chk("lat_t1_data",   32'(bus.m_data), 'hA5);
    chk("lat_t1_grant",  32'(grant_id), 0);
    chk("lat_t1_busy",   32'(busy), 1);
    @(negedge clk);
    chk("lat_t2_ready",  32'(bus.req0_ready), 1);
    chk("lat_t2_err",    32'(bus.req0_err), 0);
    chk("lat_t2_mvalid", 32'(bus.m_valid), 0);
    #1 bus.req0_valid = 1'b0;

    // Out-of-range address from req1: error completion one cycle after sampling.
    @(posedge clk); #1;
    drv(1'b1, 8'h30, 8'h5A, 1'b0);
    @(negedge clk);
    chk("oor_t0_mvalid", 32'(bus.m_valid), 0);
    @(negedge clk);
    chk("oor_t1_ready",  32'(bus.req1_ready), 1);
    chk("oor_t1_err",    32'(bus.req1_err), 1);
    chk("oor_t1_mvalid", 32'(bus.m_valid), 0);
    chk("oor_errcnt",    32'(err_count), exp_ec);
    #1 bus.req1_valid = 1'b0;

    // Range edges on both requesters.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drv(i[0] ? 1'b0 : 1'b1, tbl_a[i], 8'(8'h40 + i), 1'b0);
      run(1, n, mv);
      chk("edge_mv", mv, (tbl_a[i] >= 8'h20 && tbl_a[i] <= 8'h24) ? 1 : 0);
      chk("edge_errcnt", 32'(err_count), exp_ec);
    end

    // Timeout: m_valid held exactly 16 cycles, then an error completion.
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    drv(1'b0, 8'h23, 8'hC3, 1'b1);
    run(1, n, mv);
    chk("tmo_mv_cycles", mv, 16);
    chk("tmo_errcnt", 32'(err_count), exp_ec);

    // m_ready arriving on the final timeout cycle completes normally.
    @(posedge clk); #1;
    drv(1'b0, 8'h23, 8'h3C, 1'b0);
    mv = 0;
    for (int c = 0; c < 100 && mv < 15; c++) begin
      @(negedge clk);
      if (bus.m_valid) mv++;
    end
    chk("late_pre_mv", mv, 15);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    run(1, n, mv2);
    chk("late_mv_cycles", mv + mv2, 16);
    chk("late_errcnt", 32'(err_count), exp_ec);

    // Reset in the middle of ISSUE: abort with no completion.
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 8'h20; bus.req0_data = 8'h77;
    repeat (4) @(negedge clk);
    chk("mid_pre_mvalid", 32'(bus.m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_mvalid", 32'(bus.m_valid), 0);
    chk("mid_busy",   32'(busy), 0);
    chk("mid_errcnt", 32'(err_count), 0);
    chk("mid_ready",  32'({bus.req0_ready, bus.req1_ready}), 0);
    bus.req0_valid = 1'b0;
    bus.m_ready = 1'b1;
    exp_ec = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready || bus.m_valid) seen++;
    end
    chk("mid_no_rsp", seen, 0);

    // Error counter saturation.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      drv(1'b1, 8'h30, 8'(i), 1'b0);
      run(1, n, mv);
    end
    chk("sat_errcnt", 32'(err_count), exp_ec);
    chk("sat_model",  exp_ec, 255);

    repeat (3) @(negedge clk);
    chk("sb_mq_empty", mq.size(), 0);
    chk("sb_rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/amba_write_arbiter.md
AMBA_WRITE_ARBITER -- requirements
Module: amba_write_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the number of ISSUE cycles without m_ready before the transfer is aborted.
REQ-002 Parameter ADDR_MIN, default 8'h20, is the lowest legal target address.
REQ-003 Parameter ADDR_MAX, default 8'h24, is the highest legal target address.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req0_valid / req1_valid  in  1  requester N holds a write request pending.
REQ-007 req0_addr / req1_addr  in  8  requester N target address.
REQ-008 req0_data / req1_data  in  8  requester N write data.
REQ-009 req0_ready / req1_ready  out  1  one-cycle completion pulse to requester N.
REQ-010 req0_err / req1_err  out  1  error flag, valid only while reqN_ready=1.
REQ-011 m_valid  out  1  downstream write valid.
REQ-012 m_addr  out  8  downstream address.
REQ-013 m_data  out  8  downstream data.
REQ-014 m_ready  in  1  downstream accept.
REQ-015 grant_id  out  1  requester owning the current transaction.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 err_count  out  8  saturating count of error completions.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, RESP and ERR, and all outputs SHALL be registered.
- IDLE: if any reqN_valid, arbitrate, latch that requester's addr/data, set grant_id, then go to ISSUE if ADDR_MIN<=addr<=ADDR_MAX, else go to ERR.
REQ-019 Arbitration SHALL be round-robin.
- If both are valid, the requester not granted last wins.
- If only one is valid, it wins regardless of history.
REQ-020 ISSUE: m_valid=1, and m_addr/m_data SHALL hold the latched values stable until the cycle m_valid&&m_ready.
- On that cycle, go to RESP.
REQ-021 ISSUE timeout: an 8-bit counter increments each ISSUE cycle with m_ready=0.
- When the count reaches TIMEOUT_CYCLES-1 with m_ready still 0, drop m_valid next cycle and go to ERR.
- If m_ready=1 on that same cycle, it takes priority: the transfer completes and the FSM goes to RESP.
REQ-022 RESP: pulse req[grant_id]_ready=1 with err=0 for exactly one cycle, update the last-grant pointer, and return to IDLE.
REQ-023 ERR: pulse req[grant_id]_ready=1 and err=1 for exactly one cycle, increment err_count (saturating at 255), update the last-grant pointer, and return to IDLE.
- Out-of-range addresses SHALL never assert m_valid.
REQ-024 Latency: a request sampled in IDLE at cycle T SHALL give m_valid at T+1.
- With m_ready already high, ready pulses at T+2 and the next grant is possible at T+3.
- A legal transfer therefore takes 3 cycles minimum.
REQ-025 A requester's valid/addr/data changes while it is granted SHALL be ignored.
- Valid still high in the cycle after its ready pulse SHALL be treated as a new request.
REQ-026 The non-granted requester SHALL see ready=0 and err=0 throughout.
- It may hold valid indefinitely without side effects.
REQ-027 m_valid SHALL never be deasserted before m_ready except on timeout.

Reset
REQ-028 On rst_n=0, asynchronously:
- state=IDLE
- m_valid=0, m_addr=0, m_data=0
- req0/1_ready=0, req0/1_err=0
- grant_id=0, busy=0, err_count=0, timeout counter=0
- last-grant pointer=1, so requester 0 wins the first tie.
REQ-029 Reset asserted mid-transaction SHALL abort the transfer with no ready pulse to the requester.
- m_valid SHALL drop in the same cycle reset asserts.

Structure
REQ-030 Package amba_pkg SHALL hold:
- the state enum arb_state_t (IDLE, ISSUE, RESP, ERR);
- the address constants ADDR_CTRL=8'h20, ADDR_TX_SLOT=8'h21, ADDR_RX_SLOT=8'h22, ADDR_INT_B0=8'h23, ADDR_INT_B1=8'h24.
REQ-031 Round-robin selection SHALL be one sub-module, amba_rr_arb2.
- Inputs: two valids and the last-grant pointer.
- Outputs: grant valid and grant index.
- It SHALL be purely combinational.

Verification
REQ-032 req0 writes addr 8'h21, data 8'hA5, with m_ready tied 1 -> m_valid at T+1 with m_addr=21/m_data=A5, req0_ready=1/err=0 at T+2, grant_id=0.
REQ-033 Both valid at once after reset (req0 addr 20, req1 addr 22) -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
REQ-034 req1 writes addr 8'h30 -> m_valid never asserted, req1_ready=1/err=1 at T+1, err_count=1.
REQ-035 req0 writes addr 8'h23 with m_ready held 0 and TIMEOUT_CYCLES=16 -> m_valid high for exactly 16 cycles, then req0_ready=1/err=1, err_count increments.
REQ-036 m_ready=1 arrives on the final timeout cycle -> normal completion with err=0; separately, rst_n pulsed low mid-ISSUE -> m_valid=0 at once, no ready pulse, err_count=0.
